// File: rtl/fmt_receiver_if.sv
// Formatter handshake, buffered output stream, framing status and per-channel packet counters.
interface fmt_receiver_if;
   logic        fmt_req_i;
   logic [1:0]  fmt_chid_i;
   logic [5:0]  fmt_length_i;
   logic        fmt_grant_o;
   logic [31:0] fmt_data_i;
   logic        fmt_start_i;
   logic        fmt_end_i;
   logic [31:0] out_data_o;
   logic [1:0]  out_chid_o;
   logic        out_last_o;
   logic        out_vld_o;
   logic        out_ready_i;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic [15:0] ch0_pkt_cnt_o;
   logic [15:0] ch1_pkt_cnt_o;
   logic [15:0] ch2_pkt_cnt_o;

   modport master (
      output fmt_req_i, fmt_chid_i, fmt_length_i, fmt_data_i, fmt_start_i, fmt_end_i, out_ready_i,
      input  fmt_grant_o, out_data_o, out_chid_o, out_last_o, out_vld_o, err_o, err_code_o,
      input  ch0_pkt_cnt_o, ch1_pkt_cnt_o, ch2_pkt_cnt_o
   );

   modport slave (
      input  fmt_req_i, fmt_chid_i, fmt_length_i, fmt_data_i, fmt_start_i, fmt_end_i, out_ready_i,
      output fmt_grant_o, out_data_o, out_chid_o, out_last_o, out_vld_o, err_o, err_code_o,
      output ch0_pkt_cnt_o, ch1_pkt_cnt_o, ch2_pkt_cnt_o
   );
endinterface

// File: rtl/fmt_receiver.sv
// Formatter receive endpoint: grants only when a whole packet fits, buffers tagged words, checks framing.
// Grant one cycle after the request is seen; a captured word is at the head after its edge; sink stalls via out_ready_i.
module fmt_receiver #(
   parameter int FIFO_DEPTH  = 64,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   fmt_receiver_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, GRANT, WAIT_START, RECV} state_t;

   typedef struct packed {
      logic        last;
      logic [1:0]  chid;
      logic [31:0] data;
   } entry_t;

   state_t        state;
   entry_t        mem [FIFO_DEPTH];
   entry_t        head;
   entry_t        push_dat;
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic [1:0]    chid_q;
   logic [5:0]    len_q;
   logic [5:0]    wcnt;
   logic [5:0]    word_n;
   logic [TW-1:0] tcnt;
   logic          grant_q, err_q;
   logic [1:0]    code_q;
   logic [15:0]   cnt0_q, cnt1_q, cnt2_q;
   logic          vld, pop, push, fin, space_ok;
   logic [1:0]    fin_code;

   assign vld  = (count != '0);
   assign pop  = vld & bus.out_ready_i;
   assign head = mem[rptr];

   assign space_ok = bus.fmt_req_i && (bus.fmt_length_i != 6'd0) &&
                     (CW'(bus.fmt_length_i) <= (CW'(FIFO_DEPTH) - count));

   // The word captured this cycle and whether it ends the packet (00 normal, 01 short, 10 long).
   // Start is not honoured while the grant pulse itself is on the bus.
   always_comb begin
      push     = 1'b0;
      push_dat = '0;
      fin      = 1'b0;
      fin_code = 2'b00;
      word_n   = (state == WAIT_START) ? 6'd1 : wcnt + 6'd1;
      if ((state == RECV) || ((state == WAIT_START) && !grant_q && bus.fmt_start_i)) begin
         push          = 1'b1;
         push_dat.chid = chid_q;
         push_dat.data = bus.fmt_data_i;
         if (bus.fmt_end_i || (word_n == len_q)) begin
            fin           = 1'b1;
            push_dat.last = 1'b1;
            if (!bus.fmt_end_i)
               fin_code = 2'b10;
            else if (word_n != len_q)
               fin_code = 2'b01;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state   <= IDLE;
         chid_q  <= '0;
         len_q   <= '0;
         wcnt    <= '0;
         tcnt    <= '0;
         grant_q <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 2'b00;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
         cnt2_q  <= '0;
      end else begin
         grant_q <= 1'b0;
         err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (space_ok) begin
                  chid_q <= bus.fmt_chid_i;
                  len_q  <= bus.fmt_length_i;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               grant_q <= 1'b1;
               tcnt    <= '0;
               state   <= WAIT_START;
            end
            WAIT_START: begin
               if (push) begin
                  wcnt  <= 6'd1;
                  state <= fin ? IDLE : RECV;
               end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                  err_q  <= 1'b1;
                  code_q <= 2'b11;
                  state  <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            RECV: begin
               wcnt <= word_n;
               if (fin)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (fin) begin
            if (fin_code != 2'b00) begin
               err_q  <= 1'b1;
               code_q <= fin_code;
            end else begin
               case (chid_q)
                  2'd0:    cnt0_q <= cnt0_q + 16'd1;
                  2'd1:    cnt1_q <= cnt1_q + 16'd1;
                  2'd2:    cnt2_q <= cnt2_q + 16'd1;
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         mem[wptr] <= push_dat;
   end

   // Overflow is impossible because a grant is only given when the whole packet fits.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign bus.fmt_grant_o   = grant_q;
   assign bus.out_vld_o     = vld;
   assign bus.out_data_o    = vld ? head.data : 32'd0;
   assign bus.out_chid_o    = vld ? head.chid : 2'd0;
   assign bus.out_last_o    = vld & head.last;
   assign bus.err_o         = err_q;
   assign bus.err_code_o    = code_q;
   assign bus.ch0_pkt_cnt_o = cnt0_q;
   assign bus.ch1_pkt_cnt_o = cnt1_q;
   assign bus.ch2_pkt_cnt_o = cnt2_q;
endmodule

// File: tb/tb_fmt_receiver.sv
// Directed and randomized packet traffic against a packet-level reference model of the receiver.
module tb_fmt_receiver;
   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   fmt_receiver_if bus();

   fmt_receiver #(.FIFO_DEPTH(64), .TIMEOUT_CYC(16)) dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .bus    (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          pops   = 0;
   int          ready_mode = 0;   // 0 hold low, 1 hold high, 2 random
   logic [34:0] exp_q [$];
   logic [15:0] exp_cnt [3];
   logic [1:0]  exp_code = 2'b00;
   logic [1:0]  cur_chid;
   logic [5:0]  cur_len;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_counters();
      chk("ch0_cnt", 64'(bus.ch0_pkt_cnt_o), 64'(exp_cnt[0]));
      chk("ch1_cnt", 64'(bus.ch1_pkt_cnt_o), 64'(exp_cnt[1]));
      chk("ch2_cnt", 64'(bus.ch2_pkt_cnt_o), 64'(exp_cnt[2]));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_grant", 64'(bus.fmt_grant_o), 64'(0));
      chk("rst_vld",   64'(bus.out_vld_o),   64'(0));
      chk("rst_err",   64'(bus.err_o),       64'(0));
      chk("rst_code",  64'(bus.err_code_o),  64'(0));
      chk("rst_data",  64'(bus.out_data_o),  64'(0));
      chk("rst_chid",  64'(bus.out_chid_o),  64'(0));
      chk("rst_last",  64'(bus.out_last_o),  64'(0));
      chk_counters();
   endtask

   // One clock: pick ready, score any pop at the negedge, return just after the rising edge.
   task automatic step();
      logic [34:0] e;
      if (ready_mode == 2)
         bus.out_ready_i = 1'($urandom_range(0, 3) != 0);
      else
         bus.out_ready_i = 1'(ready_mode == 1);
      @(negedge clk);
      if (bus.out_vld_o && bus.out_ready_i) begin
         pops++;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 35'bx;
         chk("pop_word", {29'd0, bus.out_last_o, bus.out_chid_o, bus.out_data_o}, 64'(e));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [1:0] ch, input logic [5:0] len, input int exact);
      int n = 0;
      bus.fmt_req_i    = 1'b1;
      bus.fmt_chid_i   = ch;
      bus.fmt_length_i = len;
      cur_chid = ch;
      cur_len  = len;
      do begin
         step();
         n++;
      end while (!bus.fmt_grant_o && n < 400);
      bus.fmt_req_i    = 1'b0;
      bus.fmt_chid_i   = 2'($urandom);
      bus.fmt_length_i = 6'($urandom);
      chk("grant_seen", 64'(bus.fmt_grant_o), 64'(1));
      if (exact != 0)
         chk("grant_latency", 64'(n), 64'(exact));
   endtask

   // Words kept = up to the end marker, capped at the announced length; the last kept word is tagged last.
   task automatic send_words(input int nwords, input int endpos, input int delay);
      int          cap;
      logic [1:0]  code;
      logic [31:0] d;
      cap  = (endpos != 0 && endpos <= int'(cur_len)) ? endpos : int'(cur_len);
      code = (endpos == int'(cur_len)) ? 2'b00 :
             (endpos != 0 && endpos < int'(cur_len)) ? 2'b01 : 2'b10;
      step();
      chk("grant_one_cycle", 64'(bus.fmt_grant_o), 64'(0));
      repeat (delay) step();
      for (int i = 1; i <= nwords; i++) begin
         d = $urandom;
         bus.fmt_data_i  = d;
         bus.fmt_start_i = (i == 1) || ($urandom_range(0, 7) == 0);
         bus.fmt_end_i   = (i == endpos);
         if (i <= cap)
            exp_q.push_back({i == cap, cur_chid, d});
         step();
         if (i == cap) begin
            if (code == 2'b00)
               exp_cnt[cur_chid]++;
            else
               exp_code = code;
            chk("err_pulse", 64'(bus.err_o), 64'(code != 2'b00));
            chk("err_code", 64'(bus.err_code_o), 64'(exp_code));
            chk_counters();
         end else begin
            chk("err_quiet", 64'(bus.err_o), 64'(0));
         end
      end
      bus.fmt_start_i = 1'b0;
      bus.fmt_end_i   = 1'b0;
      step();
      chk("err_one_cycle", 64'(bus.err_o), 64'(0));
   endtask

   task automatic drain();
      int n = 0;
      ready_mode = 1;
      while (exp_q.size() != 0 && n < 300) begin
         step();
         n++;
      end
      chk("drained", 64'(exp_q.size()), 64'(0));
      chk("empty_vld", 64'(bus.out_vld_o), 64'(0));
   endtask

   initial begin
      int n;
      int len_tab [4] = '{4, 8, 16, 32};
      logic [1:0] ch;
      logic [5:0] ln;
      int kind, endp, nw;

      bus.fmt_req_i = 1'b0; bus.fmt_chid_i = 2'd0; bus.fmt_length_i = 6'd0;
      bus.fmt_data_i = 32'd0; bus.fmt_start_i = 1'b0; bus.fmt_end_i = 1'b0;
      bus.out_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) exp_cnt[c] = 16'd0;

      #2 rstn = 1'b0;
      #10;
      chk_reset_outputs();
      @(posedge clk);
      #1 rstn = 1'b1;

      // Single packet, buffered then drained
      ready_mode = 0;
      request(2'd1, 6'd8, 2);
      send_words(8, 8, 0);
      chk("single_vld", 64'(bus.out_vld_o), 64'(1));
      drain();

      // Backpressure: two full-size packets fill the buffer, the third waits for room
      ready_mode = 0;
      request(2'd0, 6'd32, 0);
      send_words(32, 32, 2);
      request(2'd2, 6'd32, 0);
      send_words(32, 32, 0);
      bus.fmt_req_i = 1'b1; bus.fmt_chid_i = 2'd1; bus.fmt_length_i = 6'd4;
      cur_chid = 2'd1; cur_len = 6'd4;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("no_grant_full", 64'(bus.fmt_grant_o), 64'(0));
      end
      pops = 0;
      ready_mode = 1;
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.fmt_grant_o && n < 100);
      bus.fmt_req_i = 1'b0;
      chk("bp_grant", 64'(bus.fmt_grant_o), 64'(1));
      chk("bp_pops_before_grant", 64'(pops), 64'(6));
      send_words(4, 4, 0);
      drain();

      // Short packet
      request(2'd2, 6'd16, 0);
      send_words(16, 10, 1);
      drain();

      // Long packet with two trailing words
      request(2'd0, 6'd4, 0);
      send_words(6, 0, 0);
      drain();

      // Timeout: no start after the grant
      request(2'd2, 6'd4, 0);
      for (int k = 1; k <= 16; k++) begin
         step();
         chk("timeout_err", 64'(bus.err_o), 64'(k == 16));
      end
      exp_code = 2'b11;
      chk("timeout_code", 64'(bus.err_code_o), 64'(exp_code));
      request(2'd1, 6'd4, 2);
      send_words(4, 4, 0);
      drain();

      // Randomized mix of normal, short and long packets with a random sink
      for (int p = 0; p < 12; p++) begin
         ready_mode = 2;
         ch   = 2'($urandom_range(0, 2));
         ln   = 6'(len_tab[$urandom_range(0, 3)]);
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            endp = int'(ln); nw = int'(ln);
         end else if (kind == 1) begin
            endp = $urandom_range(1, int'(ln) - 1); nw = endp;
         end else begin
            endp = 0; nw = int'(ln) + $urandom_range(0, 3);
         end
         request(ch, ln, 0);
         send_words(nw, endp, $urandom_range(0, 5));
      end
      drain();

      // Counter wrap on channel 0
      force dut.cnt0_q = 16'hFFFF;
      step();
      release dut.cnt0_q;
      exp_cnt[0] = 16'hFFFF;
      chk_counters();
      request(2'd0, 6'd4, 0);
      send_words(4, 4, 0);
      chk("ch0_wrap", 64'(bus.ch0_pkt_cnt_o), 64'(0));
      drain();

      // Reset in the middle of a packet
      ready_mode = 0;
      request(2'd1, 6'd8, 0);
      step();
      for (int i = 1; i <= 3; i++) begin
         bus.fmt_data_i  = $urandom;
         bus.fmt_start_i = (i == 1);
         step();
      end
      chk("pre_reset_vld", 64'(bus.out_vld_o), 64'(1));
      rstn = 1'b0;
      bus.fmt_start_i = 1'b0;
      #2;
      exp_q.delete();
      for (int c = 0; c < 3; c++) exp_cnt[c] = 16'd0;
      exp_code = 2'b00;
      chk_reset_outputs();
      #1 rstn = 1'b1;
      step();
      request(2'd2, 6'd8, 2);
      send_words(8, 8, 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
